fsmc_mux_slave: RTL

- Parametrised FSMC multiplexed-AD-bus slave for the MCU-to-FPGA link.
- Decodes a base address plus an N-bit channel field into one-hot channel selects.
- Delivers single-cycle write strobes and read requests to user modules, and drives read data back with a configurable hold.
- Adds an explicit transaction FSM, NE qualification, configurable synchroniser depth, a timeout and a protocol-error counter.

---
 rtl/fsmc_mux_slave_if.sv | 14 +
 rtl/fsmc_mux_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_mux_slave_if.sv
// FSMC multiplexed address/data bus: shared AD lines plus the active-low strobes
// driven by the MCU.
interface fsmc_mux_slave_if #(
  parameter int ADDR_WIDTH = 18
);
  wire  [ADDR_WIDTH-1:0] AD;
  logic                  NE;
  logic                  NADV;
  logic                  NWE;
  logic                  NOE;

  modport master (inout AD, output NE, output NADV, output NWE, output NOE);
  modport slave  (inout AD, input  NE, input  NADV, input  NWE, input  NOE);
endinterface

// File: rtl/fsmc_mux_slave.sv
// FSMC multiplexed-AD slave: decodes base address plus channel field into one-hot selects,
// issues write strobes / read requests and drives read data back with a post-NOE hold.
module fsmc_mux_slave #(
  parameter int ADDR_WIDTH     = 18,
  parameter int DATA_WIDTH     = 16,
  parameter int CH_BITS        = 2,
  parameter logic [ADDR_WIDTH-CH_BITS-1:0] BASE_ADDR = 16'h0040,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               reset_n,
  fsmc_mux_slave_if.slave                    bus,
  input  logic [(2**CH_BITS)*DATA_WIDTH-1:0] rd_data,
  output logic [(2**CH_BITS)-1:0]            ch_sel,
  output logic [DATA_WIDTH-1:0]              wr_data,
  output logic [(2**CH_BITS)-1:0]            wr_strobe,
  output logic [(2**CH_BITS)-1:0]            rd_req,
  output logic                               busy,
  output logic [7:0]                         err_count
);

  localparam int NUM_CH = 2**CH_BITS;
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, ADDR_OK, WRITE, READ, HOLD} state_t;

  state_t                  state_reg, state_next;
  logic [4*SYNC_STAGES-1:0] sync_reg;
  logic [3:0]              prev_reg;
  logic                    s_ne, s_nadv, s_nwe, s_noe;
  logic                    ne_rise, nadv_rise, nadv_fall, nwe_rise, noe_rise;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [NUM_CH-1:0]       ch_sel_reg, ch_sel_next;
  logic [NUM_CH-1:0]       wr_strobe_reg, wr_strobe_next;
  logic [NUM_CH-1:0]       rd_req_reg, rd_req_next;
  logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
  logic [DATA_WIDTH-1:0]   drv_reg, drv_next;
  logic                    drv_en_reg, drv_en_next;
  logic [TW-1:0]           tmo_reg, tmo_next;
  logic [HW-1:0]           hold_reg, hold_next;
  logic [7:0]              err_reg, err_next;
  logic                    err_inc;
  logic                    addr_match;
  logic [NUM_CH-1:0]       ch_decode;
  logic [DATA_WIDTH-1:0]   rd_masked [NUM_CH];
  logic [DATA_WIDTH-1:0]   rd_sel;

  // Control order in each sync word: {NE, NADV, NWE, NOE}; oldest stage at the top.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '1;
      prev_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[4*SYNC_STAGES-5:0], bus.NE, bus.NADV, bus.NWE, bus.NOE};
      prev_reg <= sync_reg[4*SYNC_STAGES-1 -: 4];
    end
  end

  assign {s_ne, s_nadv, s_nwe, s_noe} = sync_reg[4*SYNC_STAGES-1 -: 4];
  assign ne_rise   = ~prev_reg[3] & s_ne;
  assign nadv_rise = ~prev_reg[2] & s_nadv;
  assign nadv_fall =  prev_reg[2] & ~s_nadv;
  assign nwe_rise  = ~prev_reg[1] & s_nwe;
  assign noe_rise  = ~prev_reg[0] & s_noe;

  // Raw AD is sampled; the host holds it long enough to cover the synchroniser delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      if (!s_nadv) addr_reg <= bus.AD;
      if (!s_nwe)  data_reg <= bus.AD[DATA_WIDTH-1:0];
    end
  end

  assign addr_match = (addr_reg[ADDR_WIDTH-1:CH_BITS] == BASE_ADDR);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_decode[gi] = (addr_reg[CH_BITS-1:0] == CH_BITS'(gi));
      assign rd_masked[gi] = rd_data[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{ch_sel_reg[gi]}};
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_CH; k++) rd_sel = rd_sel | rd_masked[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      ch_sel_reg    <= '0;
      wr_strobe_reg <= '0;
      rd_req_reg    <= '0;
      wr_data_reg   <= '0;
      drv_reg       <= '0;
      drv_en_reg    <= 1'b0;
      tmo_reg       <= '0;
      hold_reg      <= '0;
      err_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      ch_sel_reg    <= ch_sel_next;
      wr_strobe_reg <= wr_strobe_next;
      rd_req_reg    <= rd_req_next;
      wr_data_reg   <= wr_data_next;
      drv_reg       <= drv_next;
      drv_en_reg    <= drv_en_next;
      tmo_reg       <= tmo_next;
      hold_reg      <= hold_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ch_sel_next    = ch_sel_reg;
    wr_strobe_next = '0;
    rd_req_next    = '0;
    wr_data_next   = wr_data_reg;
    drv_next       = drv_reg;
    drv_en_next    = drv_en_reg;
    tmo_next       = tmo_reg;
    hold_next      = hold_reg;
    err_inc        = 1'b0;

    // NE going away or a new address phase preempts whatever transaction is open.
    if (state_reg != IDLE && ne_rise) begin
      err_inc     = (state_reg != HOLD);
      state_next  = IDLE;
      ch_sel_next = '0;
      drv_en_next = 1'b0;
    end else if (state_reg != IDLE && nadv_fall) begin
      err_inc     = 1'b1;
      state_next  = IDLE;
      ch_sel_next = '0;
      drv_en_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (nadv_rise && !s_ne && addr_match) begin
            state_next  = ADDR_OK;
            ch_sel_next = ch_decode;
            tmo_next    = '0;
          end
        end
        ADDR_OK: begin
          tmo_next = tmo_reg + TW'(1);
          if (!s_nwe && !s_noe) begin
            err_inc     = 1'b1;
            state_next  = IDLE;
            ch_sel_next = '0;
          end else if (!s_nwe) begin
            state_next = WRITE;
          end else if (!s_noe) begin
            state_next  = READ;
            rd_req_next = ch_sel_reg;
          end else if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            err_inc     = 1'b1;
            state_next  = IDLE;
            ch_sel_next = '0;
          end
        end
        WRITE: begin
          if (nwe_rise) begin
            wr_data_next   = data_reg;
            wr_strobe_next = ch_sel_reg;
            ch_sel_next    = '0;
            state_next     = IDLE;
          end
        end
        READ: begin
          // First READ cycle: the user answered rd_req, latch its word and start driving.
          if (!drv_en_reg) begin
            drv_next    = rd_sel;
            drv_en_next = 1'b1;
          end
          if (noe_rise) begin
            if (HOLD_CYCLES == 0) begin
              state_next  = IDLE;
              ch_sel_next = '0;
              drv_en_next = 1'b0;
            end else begin
              state_next = HOLD;
              hold_next  = HW'(HOLD_CYCLES);
            end
          end
        end
        HOLD: begin
          hold_next = hold_reg - HW'(1);
          if (hold_reg <= HW'(1)) begin
            state_next  = IDLE;
            ch_sel_next = '0;
            drv_en_next = 1'b0;
          end
        end
        default: begin
          state_next  = IDLE;
          ch_sel_next = '0;
          drv_en_next = 1'b0;
        end
      endcase
    end

    err_next = (err_inc && err_reg != 8'hFF) ? err_reg + 8'd1 : err_reg;
  end

  assign bus.AD    = (drv_en_reg && reset_n) ? ADDR_WIDTH'(drv_reg) : {ADDR_WIDTH{1'bz}};
  assign ch_sel    = ch_sel_reg;
  assign wr_data   = wr_data_reg;
  assign wr_strobe = wr_strobe_reg;
  assign rd_req    = rd_req_reg;
  assign busy      = (state_reg != IDLE);
  assign err_count = err_reg;

endmodule
